resource_ejector: RTL and testbench
===================================

# resource_ejector

Per-node ejection and reassembly unit on the resource port of a bless_age bufferless router. Deflection routing delivers a packet's flits out of order, so the block tags incoming flits by source and places each flit by sequence number. It emits each completed packet to the local core over a valid/ready handshake. It is the sink-side counterpart of the flit injection that drives `b*_ci`/`b*_di`, and it consumes a router's `b*_co`/`b*_do`.

## Interface
- `NODE_ID`, default 0: this node's address, `addr_n bits wide; flits for any other destination are ignored.
- `FLITS`, default 4: flits per packet, equal to 2^`seq_n. Sequence values run 0..FLITS-1.
- `NSLOTS`, default 2: number of concurrent reassembly slots, one per in-flight source.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ci` input `control_w: flit control from the router resource output, with fields `valid_f`, `seq_f`, `src_f`, `dest_f`, `age_f`.
- `di` input `data_w: flit payload.
- `pkt_valid` output 1: a complete packet is held in the output register.
- `pkt_ready` input 1: the core accepts the packet.
- `pkt_src` output `addr_n: source of the held packet.
- `pkt_data` output FLITS*`data_n: payload, with seq 0 in the LSBs.
- `drop_cnt` output 8: count of flits lost for lack of a slot.
- `dup_cnt` output 8: count of duplicate-seq flits.

## Operation
- A flit is accepted when `ci[valid_f]`=1 and `ci[dest_f]`==NODE_ID. All other flits are ignored with no state change. `age_f` is ignored.
- Each slot holds a valid bit, a src tag, a FLITS-bit arrival mask, FLITS data words and a complete bit.
- Slot lookup: if a valid slot has tag == `src_f`, the flit goes to that slot. Otherwise the lowest-index free slot is allocated with the tag set and the mask cleared. If no slot is free, the flit is dropped and `drop_cnt` increments.
- Write: `data[seq_f]`<=`di` and `mask[seq_f]`<=1. If the mask bit was already set, the data is overwritten and `dup_cnt` increments.
- A slot becomes complete when its mask is all ones. It stops matching new flits from that source until it is freed; a further flit from the same src allocates a new slot.
- Output register states:
  - EMPTY: the lowest-index complete slot is copied to `pkt_src`/`pkt_data`, the slot is freed, and the state moves to FULL.
  - FULL: holds until `pkt_valid`&&`pkt_ready`. In that cycle, if a complete slot exists it is loaded and the state stays FULL; otherwise the state moves to EMPTY.
- A slot freed on the same edge as an incoming allocation is not reusable until the next cycle. Allocation sees only free state from the previous cycle.
- Counters saturate at 8'hFF.

## Timing
- Reset values: `pkt_valid`=0, `pkt_src`=0, `pkt_data`=0, `drop_cnt`=0, `dup_cnt`=0; all slots invalid with masks clear.
- Reset asserted mid-operation discards all partial and held packets immediately, without waiting for a clock edge.
- A flit presented during cycle N is written at edge N.
- The slot's complete bit is visible after edge N.
- The packet is loaded at edge N+1, so `pkt_valid` rises after edge N+1: 2 cycles from the last flit to `pkt_valid` when the output is EMPTY.
- Back-to-back packets: with `pkt_ready` held at 1, one packet is delivered per cycle.
- `pkt_src`/`pkt_data` are stable while `pkt_valid`=1 and `pkt_ready`=0.
- The input has no backpressure. The block accepts one flit every cycle with no stall.

## Configuration
- `EJECT_STATS_EN`: when defined, `drop_cnt` and `dup_cnt` are live saturating counters.
- When undefined, both ports are tied to 8'h00 and the counter logic is not built. Drop and overwrite behaviour is unchanged.

## Test plan
- In-order packet: NODE_ID=0; flits from src 1 with seq 0,1,2,3 carrying data 0xA0..0xA3 on consecutive cycles, `pkt_ready`=1 -> `pkt_valid` for 1 cycle, 2 cycles after seq 3; `pkt_src`=1; `pkt_data`={A3,A2,A1,A0}.
- Out-of-order packet: seq 3,0,2,1 from src 5 with data 0x30,0x00,0x20,0x10 -> identical ordered `pkt_data`={30,20,10,00}; `pkt_src`=5.
- Interleaved sources: flits from src 2 and src 7 alternate, 8 flits total; `pkt_ready`=0 until both complete -> src 2 is held first. Raising `pkt_ready` delivers src 2 then src 7 on consecutive cycles.
- Slot exhaustion with NSLOTS=2: a partial packet is open from each of srcs 1 and 2, then a flit from src 3 arrives -> it is dropped, `drop_cnt`=1, and src 1/2 reassembly is unaffected.
- Filtering and duplicates:
  - A flit with dest=4 -> ignored.
  - seq 1 sent twice with data 0x11 then 0x22 -> `dup_cnt`=1; the delivered word is 0x22.
  - With `EJECT_STATS_EN` undefined -> both counters read 0.
- Reset: `rst` pulled low while a packet is held and another is half received -> `pkt_valid` drops immediately. After release, a fresh 4-flit packet reassembles normally.

Source files
------------

// File: rtl/resource_ejector.sv
// Ejection and reassembly unit for the bless_age resource port: tags flits by source, places them
// by sequence number and hands completed packets to the core. Optional counters: EJECT_STATS_EN.
`ifndef ADDR_N
`define ADDR_N 3
`endif
`ifndef SEQ_N
`define SEQ_N 2
`endif
`ifndef DATA_N
`define DATA_N 8
`endif
`ifndef DATA_W
`define DATA_W `DATA_N
`endif
`ifndef CONTROL_W
`define CONTROL_W 13
`endif
`ifndef VALID_F
`define VALID_F 0
`endif
`ifndef SEQ_F
`define SEQ_F 2:1
`endif
`ifndef SRC_F
`define SRC_F 5:3
`endif
`ifndef DEST_F
`define DEST_F 8:6
`endif
`ifndef AGE_F
`define AGE_F 12:9
`endif

module resource_ejector #(
   parameter logic [`ADDR_N-1:0] NODE_ID = '0,
   parameter int FLITS  = 4,
   parameter int NSLOTS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [`CONTROL_W-1:0]    ci,
   input  logic [`DATA_W-1:0]       di,
   output logic                     pkt_valid,
   input  logic                     pkt_ready,
   output logic [`ADDR_N-1:0]       pkt_src,
   output logic [FLITS*`DATA_N-1:0] pkt_data,
   output logic [7:0]               drop_cnt,
   output logic [7:0]               dup_cnt
);
   localparam int DW = `DATA_W;
   localparam int SW = `SEQ_N;
   localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

   typedef enum logic {EMPTY, FULL} out_state_e;

   logic [NSLOTS-1:0]                 valid_q, valid_d;
   logic [NSLOTS-1:0][`ADDR_N-1:0]    tag_q, tag_d;
   logic [NSLOTS-1:0][FLITS-1:0]      mask_q, mask_d;
   logic [NSLOTS-1:0][FLITS*DW-1:0]   data_q, data_d;
   out_state_e                        state_q, state_d;
   logic [`ADDR_N-1:0]                pkt_src_q, pkt_src_d;
   logic [FLITS*DW-1:0]               pkt_data_q, pkt_data_d;

   logic               flit_ok, hit, free_ok, cmp_ok, load, alloc, wr_en;
   logic [SW-1:0]      seq;
   logic [`ADDR_N-1:0] src;
   logic [IW-1:0]      hit_idx, free_idx, cmp_idx, wr_idx;
   logic [NSLOTS-1:0]  complete;
   logic               unused_age;

   assign flit_ok    = ci[`VALID_F] && (ci[`DEST_F] == NODE_ID);
   assign seq        = ci[`SEQ_F];
   assign src        = ci[`SRC_F];
   assign unused_age = ^ci[`AGE_F];

   // Lowest-index search for a matching open slot, a free slot and a finished slot.
   always_comb begin
      complete = '0;
      hit      = 1'b0;
      hit_idx  = '0;
      free_ok  = 1'b0;
      free_idx = '0;
      cmp_ok   = 1'b0;
      cmp_idx  = '0;
      for (int s = 0; s < NSLOTS; s++) begin
         complete[s] = valid_q[s] && (&mask_q[s]);
         if (!hit && valid_q[s] && !complete[s] && (tag_q[s] == src)) begin
            hit     = 1'b1;
            hit_idx = IW'(s);
         end
         if (!free_ok && !valid_q[s]) begin
            free_ok  = 1'b1;
            free_idx = IW'(s);
         end
         if (!cmp_ok && complete[s]) begin
            cmp_ok  = 1'b1;
            cmp_idx = IW'(s);
         end
      end
   end

   assign load   = cmp_ok && ((state_q == EMPTY) || pkt_ready);
   assign alloc  = flit_ok && !hit && free_ok;
   assign wr_en  = flit_ok && (hit || free_ok);
   assign wr_idx = hit ? hit_idx : free_idx;

   // A loaded slot is complete, so it can never be the slot written by the incoming flit.
   always_comb begin
      valid_d    = valid_q;
      tag_d      = tag_q;
      mask_d     = mask_q;
      data_d     = data_q;
      state_d    = state_q;
      pkt_src_d  = pkt_src_q;
      pkt_data_d = pkt_data_q;
      if (load) begin
         valid_d[cmp_idx] = 1'b0;
         mask_d[cmp_idx]  = '0;
         pkt_src_d        = tag_q[cmp_idx];
         pkt_data_d       = data_q[cmp_idx];
         state_d          = FULL;
      end else if ((state_q == FULL) && pkt_ready) begin
         state_d = EMPTY;
      end
      if (alloc) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = src;
         mask_d[wr_idx]  = '0;
      end
      if (wr_en) begin
         mask_d[wr_idx][seq]           = 1'b1;
         data_d[wr_idx][seq*DW +: DW]  = di;
      end
   end

   // NOTE: sequential state uses <= so every flop samples values from before the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= EMPTY;
         valid_q    <= '0;
         tag_q      <= '0;
         mask_q     <= '0;
         pkt_src_q  <= '0;
         pkt_data_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         mask_q     <= mask_d;
         pkt_src_q  <= pkt_src_d;
         pkt_data_q <= pkt_data_d;
      end
   end

   // NOTE: payload storage is not reset; the valid and mask bits alone say whether it holds anything.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign pkt_valid = (state_q == FULL);
   assign pkt_src   = pkt_src_q;
   assign pkt_data  = pkt_data_q;

`ifdef EJECT_STATS_EN
   logic       drop_ev, dup_ev;
   logic [7:0] drop_q, drop_d, dup_q, dup_d;

   assign drop_ev = flit_ok && !hit && !free_ok;
   assign dup_ev  = flit_ok && hit && mask_q[hit_idx][seq];

   always_comb begin
      drop_d = drop_q;
      dup_d  = dup_q;
      if (drop_ev && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
      if (dup_ev && (dup_q != 8'hFF))   dup_d  = dup_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_q <= 8'h00;
         dup_q  <= 8'h00;
      end else begin
         drop_q <= drop_d;
         dup_q  <= dup_d;
      end
   end

   assign drop_cnt = drop_q;
   assign dup_cnt  = dup_q;
`else
   assign drop_cnt = 8'h00;
   assign dup_cnt  = 8'h00;
`endif

endmodule

// File: tb/tb_resource_ejector.sv
// Directed bench for resource_ejector: ordering, interleaving, slot exhaustion, filtering,
// duplicates and asynchronous reset, with hand-computed expectations.
`ifndef ADDR_N
`define ADDR_N 3
`endif
`ifndef SEQ_N
`define SEQ_N 2
`endif
`ifndef DATA_N
`define DATA_N 8
`endif
`ifndef DATA_W
`define DATA_W `DATA_N
`endif
`ifndef CONTROL_W
`define CONTROL_W 13
`endif
`ifndef VALID_F
`define VALID_F 0
`endif
`ifndef SEQ_F
`define SEQ_F 2:1
`endif
`ifndef SRC_F
`define SRC_F 5:3
`endif
`ifndef DEST_F
`define DEST_F 8:6
`endif
`ifndef AGE_F
`define AGE_F 12:9
`endif

module tb_resource_ejector;
   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [`CONTROL_W-1:0] ci = '0;
   logic [`DATA_W-1:0]    di = '0;
   logic                  pkt_valid;
   logic                  pkt_ready = 1'b1;
   logic [`ADDR_N-1:0]    pkt_src;
   logic [4*`DATA_N-1:0]  pkt_data;
   logic [7:0]            drop_cnt;
   logic [7:0]            dup_cnt;

   int tests = 0;
   int fails = 0;

`ifdef EJECT_STATS_EN
   localparam logic [7:0] STATS_ONE = 8'd1;
`else
   localparam logic [7:0] STATS_ONE = 8'd0;
`endif

   resource_ejector #(.NODE_ID('0), .FLITS(4), .NSLOTS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ci        (ci),
      .di        (di),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_src   (pkt_src),
      .pkt_data  (pkt_data),
      .drop_cnt  (drop_cnt),
      .dup_cnt   (dup_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [`ADDR_N-1:0] src, input logic [`SEQ_N-1:0] seq,
                       input logic [7:0] data, input logic [`ADDR_N-1:0] dest = '0,
                       input logic v = 1'b1);
      ci           = '0;
      ci[`VALID_F] = v;
      ci[`SEQ_F]   = seq;
      ci[`SRC_F]   = src;
      ci[`DEST_F]  = dest;
      ci[`AGE_F]   = data[3:0];
      di           = data;
      tick();
      ci = '0;
      di = '0;
   endtask

   initial begin
      // Reset values while rst is held low
      #2;
      check("rst_valid", pkt_valid, 0);
      check("rst_src", pkt_src, 0);
      check("rst_data", pkt_data, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_dup", dup_cnt, 0);
      #10 rst = 1'b1;
      tick();

      // In-order packet from src 1
      pkt_ready = 1'b1;
      send(1, 0, 8'hA0);
      send(1, 1, 8'hA1);
      send(1, 2, 8'hA2);
      send(1, 3, 8'hA3);
      check("inord_lat1", pkt_valid, 0);
      tick();
      check("inord_valid", pkt_valid, 1);
      check("inord_src", pkt_src, 1);
      check("inord_data", pkt_data, 32'hA3A2A1A0);
      tick();
      check("inord_once", pkt_valid, 0);

      // Out-of-order packet from src 5
      send(5, 3, 8'h30);
      send(5, 0, 8'h00);
      send(5, 2, 8'h20);
      send(5, 1, 8'h10);
      tick();
      check("ooo_valid", pkt_valid, 1);
      check("ooo_src", pkt_src, 5);
      check("ooo_data", pkt_data, 32'h30201000);
      tick();
      check("ooo_once", pkt_valid, 0);

      // Interleaved src 2 / src 7 with the core stalled
      pkt_ready = 1'b0;
      send(2, 0, 8'h20);
      send(7, 0, 8'h70);
      send(2, 1, 8'h21);
      send(7, 1, 8'h71);
      send(2, 2, 8'h22);
      send(7, 2, 8'h72);
      send(2, 3, 8'h23);
      send(7, 3, 8'h73);
      check("intl_valid", pkt_valid, 1);
      check("intl_first_src", pkt_src, 2);
      tick();
      check("intl_hold_valid", pkt_valid, 1);
      check("intl_hold_src", pkt_src, 2);
      check("intl_hold_data", pkt_data, 32'h23222120);
      pkt_ready = 1'b1;
      tick();
      check("intl_b2b_valid", pkt_valid, 1);
      check("intl_second_src", pkt_src, 7);
      check("intl_second_data", pkt_data, 32'h73727170);
      tick();
      check("intl_drain", pkt_valid, 0);

      // Slot exhaustion: src 3 finds no free slot
      send(1, 0, 8'hB0);
      send(2, 0, 8'hC0);
      send(3, 0, 8'h33);
      check("exh_drop", drop_cnt, STATS_ONE);
      send(1, 1, 8'hB1);
      send(1, 2, 8'hB2);
      send(1, 3, 8'hB3);
      tick();
      check("exh_src1_valid", pkt_valid, 1);
      check("exh_src1_src", pkt_src, 1);
      check("exh_src1_data", pkt_data, 32'hB3B2B1B0);
      tick();
      send(2, 1, 8'hC1);
      send(2, 2, 8'hC2);
      send(2, 3, 8'hC3);
      tick();
      check("exh_src2_src", pkt_src, 2);
      check("exh_src2_data", pkt_data, 32'hC3C2C1C0);
      tick();
      check("exh_no_extra", pkt_valid, 0);
      check("exh_dup_zero", dup_cnt, 0);

      // Filtering (foreign dest, invalid flit) and a duplicate seq 1
      send(6, 0, 8'h60);
      send(6, 0, 8'hEE, 3'd4);
      send(6, 1, 8'h11);
      send(6, 1, 8'h22);
      send(6, 2, 8'h62);
      send(6, 2, 8'h99, 3'd0, 1'b0);
      send(6, 3, 8'h63);
      tick();
      check("filt_valid", pkt_valid, 1);
      check("filt_src", pkt_src, 6);
      check("filt_data", pkt_data, 32'h63622260);
      check("filt_dup", dup_cnt, STATS_ONE);
      check("filt_drop", drop_cnt, STATS_ONE);
      tick();

      // Asynchronous reset with one packet held and one half received
      pkt_ready = 1'b0;
      send(1, 0, 8'hD0);
      send(1, 1, 8'hD1);
      send(1, 2, 8'hD2);
      send(1, 3, 8'hD3);
      tick();
      check("rst2_held", pkt_valid, 1);
      check("rst2_held_data", pkt_data, 32'hD3D2D1D0);
      send(2, 0, 8'hE0);
      send(2, 1, 8'hE1);
      #2 rst = 1'b0;
      #1;
      check("rst2_valid_async", pkt_valid, 0);
      check("rst2_data_async", pkt_data, 0);
      check("rst2_src_async", pkt_src, 0);
      check("rst2_drop_async", drop_cnt, 0);
      check("rst2_dup_async", dup_cnt, 0);
      #2 rst = 1'b1;
      tick();
      pkt_ready = 1'b1;
      send(2, 2, 8'hE2);
      send(2, 3, 8'hE3);
      send(3, 0, 8'hF0);
      send(3, 1, 8'hF1);
      send(3, 2, 8'hF2);
      send(3, 3, 8'hF3);
      check("post_rst_partial", pkt_valid, 0);
      tick();
      check("post_rst_valid", pkt_valid, 1);
      check("post_rst_src", pkt_src, 3);
      check("post_rst_data", pkt_data, 32'hF3F2F1F0);
      tick();
      check("post_rst_drain", pkt_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
